// File: rtl/colision_vehiculos_pkg.sv
// Shared constants for the frog game: game-state codes, bus widths and the
// collision FSM state encoding. The ESTADO_* codes are common to the
// vehicle-level generator, this collision block and the game FSM.
package colision_vehiculos_pkg;

    localparam int CLV_DATAWIDTH_BUS    = 8;
    localparam int CLV_DATAWIDTH_ESTADO = 3;
    localparam int CLV_DATAWIDTH_VIDAS  = 2;
    localparam int CLV_FILA_W           = 3;
    localparam int CLV_COL_W            = 3;

    // Rows 0..5 carry traffic; rows 6 and 7 are safe ground.
    localparam logic [CLV_FILA_W-1:0] CLV_FILAS_CARRIL = 3'd6;

    localparam logic [CLV_DATAWIDTH_VIDAS-1:0]  CLV_VIDAS_INI     = 2'd3;
    localparam logic [CLV_DATAWIDTH_ESTADO-1:0] CLV_ESTADO_INICIO = 3'b000;
    localparam logic [CLV_DATAWIDTH_ESTADO-1:0] CLV_ESTADO_JUEGO  = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMADO = 3'd1,
        ST_CHOQUE = 3'd2,
        ST_GRACIA = 3'd3,
        ST_FIN    = 3'd4
    } clv_estado_t;

    // Life counter decrement that never wraps below zero.
    function automatic logic [CLV_DATAWIDTH_VIDAS-1:0] vidas_dec_sat(
        input logic [CLV_DATAWIDTH_VIDAS-1:0] v
    );
        if (v == '0) begin
            return '0;
        end
        return v - 1'b1;
    endfunction

endpackage

// File: rtl/colision_vehiculos_if.sv
// Bundle of lane buses, frog position, game state and collision results
// exchanged between the game top level and the collision block.
interface colision_vehiculos_if import colision_vehiculos_pkg::*; ();

    logic [CLV_DATAWIDTH_BUS-1:0]    CLV_REG_0_IN;
    logic [CLV_DATAWIDTH_BUS-1:0]    CLV_REG_1_IN;
    logic [CLV_DATAWIDTH_BUS-1:0]    CLV_REG_2_IN;
    logic [CLV_DATAWIDTH_BUS-1:0]    CLV_REG_3_IN;
    logic [CLV_DATAWIDTH_BUS-1:0]    CLV_REG_4_IN;
    logic [CLV_DATAWIDTH_BUS-1:0]    CLV_REG_5_IN;
    logic [CLV_FILA_W-1:0]           CLV_RANA_FILA_IN;
    logic [CLV_COL_W-1:0]            CLV_RANA_COL_IN;
    logic [CLV_DATAWIDTH_ESTADO-1:0] CLV_ESTADO_IN;
    logic                            CLV_CN_IN;
    logic                            CLV_CHOQUE_OUT;
    logic [CLV_DATAWIDTH_VIDAS-1:0]  CLV_VIDAS_OUT;
    logic                            CLV_GAMEOVER_OUT;

    modport master (
        output CLV_REG_0_IN, CLV_REG_1_IN, CLV_REG_2_IN,
        output CLV_REG_3_IN, CLV_REG_4_IN, CLV_REG_5_IN,
        output CLV_RANA_FILA_IN, CLV_RANA_COL_IN, CLV_ESTADO_IN, CLV_CN_IN,
        input  CLV_CHOQUE_OUT, CLV_VIDAS_OUT, CLV_GAMEOVER_OUT
    );

    modport slave (
        input  CLV_REG_0_IN, CLV_REG_1_IN, CLV_REG_2_IN,
        input  CLV_REG_3_IN, CLV_REG_4_IN, CLV_REG_5_IN,
        input  CLV_RANA_FILA_IN, CLV_RANA_COL_IN, CLV_ESTADO_IN, CLV_CN_IN,
        output CLV_CHOQUE_OUT, CLV_VIDAS_OUT, CLV_GAMEOVER_OUT
    );

endinterface

// File: rtl/colision_vehiculos_selector.sv
// Lane lookup: picks the lane bus of the frog's row, selects the frog's
// column and registers the result. Safe rows (6, 7) never report a hit.
module colision_vehiculos_selector
    import colision_vehiculos_pkg::*;
#(
    parameter int DATAWIDTH_BUS = CLV_DATAWIDTH_BUS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATAWIDTH_BUS-1:0]         reg_0,
    input  logic [DATAWIDTH_BUS-1:0]         reg_1,
    input  logic [DATAWIDTH_BUS-1:0]         reg_2,
    input  logic [DATAWIDTH_BUS-1:0]         reg_3,
    input  logic [DATAWIDTH_BUS-1:0]         reg_4,
    input  logic [DATAWIDTH_BUS-1:0]         reg_5,
    input  logic [CLV_FILA_W-1:0]            fila,
    input  logic [$clog2(DATAWIDTH_BUS)-1:0] col,
    output logic                             hit_p1
);

    logic [DATAWIDTH_BUS-1:0] lane_sel_p0;
    logic                     fila_valida_p0;
    logic                     hit_p0;

    // Row mux and column pick, qualified by the row being a traffic lane.
    always_comb begin
        lane_sel_p0 = '0;
        case (fila)
            3'd0:    lane_sel_p0 = reg_0;
            3'd1:    lane_sel_p0 = reg_1;
            3'd2:    lane_sel_p0 = reg_2;
            3'd3:    lane_sel_p0 = reg_3;
            3'd4:    lane_sel_p0 = reg_4;
            3'd5:    lane_sel_p0 = reg_5;
            default: lane_sel_p0 = '0;
        endcase
        fila_valida_p0 = (fila < CLV_FILAS_CARRIL);
        hit_p0         = fila_valida_p0 & lane_sel_p0[col];
    end

    // p0 -> p1: registered hit feeding the collision FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_p1 <= 1'b0;
        end else begin
            hit_p1 <= hit_p0;
        end
    end

endmodule

// File: rtl/colision_vehiculos.sv
// Frog/vehicle collision detector. Looks up the frog cell in the lane buses,
// emits a one-cycle collision pulse, opens a grace window of CN ticks,
// keeps the life counter and flags game over.
module colision_vehiculos
    import colision_vehiculos_pkg::*;
#(
    parameter int                              DATAWIDTH_BUS    = CLV_DATAWIDTH_BUS,
    parameter int                              DATAWIDTH_ESTADO = CLV_DATAWIDTH_ESTADO,
    parameter int                              DATAWIDTH_VIDAS  = CLV_DATAWIDTH_VIDAS,
    parameter logic [DATAWIDTH_VIDAS-1:0]      VIDAS_INI        = CLV_VIDAS_INI,
    parameter int                              GRACE_TICKS      = 4,
    parameter logic [DATAWIDTH_ESTADO-1:0]     ESTADO_INICIO    = CLV_ESTADO_INICIO,
    parameter logic [DATAWIDTH_ESTADO-1:0]     ESTADO_JUEGO     = CLV_ESTADO_JUEGO
) (
    input  logic                 CLV_CLOCK,
    input  logic                 CLV_RESET,
    colision_vehiculos_if.slave  bus
);

    localparam int CNT_W = 4;

    clv_estado_t                state, state_next;
    logic                       hit_p1;
    logic [DATAWIDTH_VIDAS-1:0] vidas;
    logic [CNT_W-1:0]           cnt;
    logic                       gameover;
    logic                       choque;
    logic                       vidas_dec;
    logic                       cnt_load;
    logic                       cnt_dec;
    logic                       en_juego;
    logic                       en_inicio;

    colision_vehiculos_selector #(
        .DATAWIDTH_BUS (DATAWIDTH_BUS)
    ) u_selector (
        .clk    (CLV_CLOCK),
        .rst    (CLV_RESET),
        .reg_0  (bus.CLV_REG_0_IN),
        .reg_1  (bus.CLV_REG_1_IN),
        .reg_2  (bus.CLV_REG_2_IN),
        .reg_3  (bus.CLV_REG_3_IN),
        .reg_4  (bus.CLV_REG_4_IN),
        .reg_5  (bus.CLV_REG_5_IN),
        .fila   (bus.CLV_RANA_FILA_IN),
        .col    (bus.CLV_RANA_COL_IN),
        .hit_p1 (hit_p1)
    );

    assign en_juego  = (bus.CLV_ESTADO_IN == ESTADO_JUEGO);
    assign en_inicio = (bus.CLV_ESTADO_IN == ESTADO_INICIO);

    // p1 -> p2: next-state and control decode acting on the registered hit.
    always_comb begin
        state_next = state;
        choque     = 1'b0;
        vidas_dec  = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en_juego) state_next = ST_ARMADO;
            end
            ST_ARMADO: begin
                // Leaving play takes precedence so a paused game never scores a hit.
                if (!en_juego)   state_next = ST_IDLE;
                else if (hit_p1) state_next = ST_CHOQUE;
            end
            ST_CHOQUE: begin
                choque    = 1'b1;
                vidas_dec = 1'b1;
                if (vidas == DATAWIDTH_VIDAS'(1)) begin
                    state_next = ST_FIN;
                end else begin
                    state_next = ST_GRACIA;
                    cnt_load   = 1'b1;
                end
            end
            ST_GRACIA: begin
                // hit_p1 is deliberately ignored while invulnerable.
                if (!en_juego) begin
                    state_next = ST_IDLE;
                end else if (bus.CLV_CN_IN) begin
                    if (cnt == CNT_W'(1)) state_next = ST_ARMADO;
                    else                  cnt_dec    = 1'b1;
                end
            end
            ST_FIN: begin
                state_next = ST_FIN;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // A new game restarts the block from any state.
        if (en_inicio) state_next = ST_IDLE;
    end

    // State, life counter, grace counter and game-over flag registers.
    always_ff @(posedge CLV_CLOCK) begin
        if (CLV_RESET) begin
            state    <= ST_IDLE;
            vidas    <= VIDAS_INI;
            cnt      <= '0;
            gameover <= 1'b0;
        end else begin
            state <= state_next;
            if (en_inicio)      vidas <= VIDAS_INI;
            else if (vidas_dec) vidas <= vidas_dec_sat(vidas);
            if (state_next != ST_GRACIA) cnt <= '0;
            else if (cnt_load)           cnt <= CNT_W'(GRACE_TICKS);
            else if (cnt_dec)            cnt <= cnt - 1'b1;
            gameover <= (state_next == ST_FIN);
        end
    end

    assign bus.CLV_CHOQUE_OUT   = choque;
    assign bus.CLV_VIDAS_OUT    = vidas;
    assign bus.CLV_GAMEOVER_OUT = gameover;

endmodule

// File: tb/tb_colision_vehiculos.sv
// Directed bench for colision_vehiculos: a table of single-hit lookups
// followed by hand-written grace, game-over, pause and reset sequences.
module tb_colision_vehiculos;
    import colision_vehiculos_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    colision_vehiculos_if bus ();

    colision_vehiculos dut (
        .CLV_CLOCK (clk),
        .CLV_RESET (rst),
        .bus       (bus)
    );

    typedef struct {
        logic [47:0] lanes;   // {reg5, reg4, reg3, reg2, reg1, reg0}
        logic [2:0]  fila;
        logic [2:0]  col;
        int          exp_hit;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_lanes(input logic [47:0] l);
        bus.CLV_REG_0_IN = l[7:0];
        bus.CLV_REG_1_IN = l[15:8];
        bus.CLV_REG_2_IN = l[23:16];
        bus.CLV_REG_3_IN = l[31:24];
        bus.CLV_REG_4_IN = l[39:32];
        bus.CLV_REG_5_IN = l[47:40];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{{8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00}, 3'd3, 3'd4, 1};
        vecs[1] = '{{8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00}, 3'd3, 3'd3, 0};
        vecs[2] = '{{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}, 3'd0, 3'd0, 1};
        vecs[3] = '{{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3'd5, 3'd7, 1};
        vecs[4] = '{{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 3'd6, 3'd0, 0};
        vecs[5] = '{{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 3'd7, 3'd7, 0};
        vecs[6] = '{{8'hFF, 8'hFF, 8'hFF, 8'hDF, 8'hFF, 8'hFF}, 3'd2, 3'd5, 0};
        vecs[7] = '{{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00}, 3'd4, 3'd1, 1};
        vecs[8] = '{{8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00}, 3'd4, 3'd1, 0};
        vecs[9] = '{{8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00}, 3'd1, 3'd1, 1};

        set_lanes('0);
        bus.CLV_RANA_FILA_IN = 3'd7;
        bus.CLV_RANA_COL_IN  = 3'd0;
        bus.CLV_ESTADO_IN    = CLV_ESTADO_JUEGO;
        bus.CLV_CN_IN        = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("reset_choque", int'(bus.CLV_CHOQUE_OUT), 0);
        chk("reset_vidas", int'(bus.CLV_VIDAS_OUT), 3);
        chk("reset_gameover", int'(bus.CLV_GAMEOVER_OUT), 0);
        rst = 1'b0;

        // Single lookups from a clean reset: pulse two cycles after the inputs.
        for (int i = 0; i < 10; i++) begin
            rst = 1'b1;
            bus.CLV_ESTADO_IN    = CLV_ESTADO_JUEGO;
            set_lanes(vecs[i].lanes);
            bus.CLV_RANA_FILA_IN = vecs[i].fila;
            bus.CLV_RANA_COL_IN  = vecs[i].col;
            tick();
            rst = 1'b0;
            tick();
            tick();
            chk($sformatf("vec%0d_choque", i), int'(bus.CLV_CHOQUE_OUT), vecs[i].exp_hit);
            tick();
            chk($sformatf("vec%0d_vidas", i), int'(bus.CLV_VIDAS_OUT), vecs[i].exp_hit != 0 ? 2 : 3);
        end

        // Setup and grace window with the frog parked on a vehicle.
        do_reset();
        bus.CLV_ESTADO_IN    = CLV_ESTADO_JUEGO;
        set_lanes({8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00});
        bus.CLV_RANA_FILA_IN = 3'd3;
        bus.CLV_RANA_COL_IN  = 3'd4;
        tick();
        chk("setup_lat1", int'(bus.CLV_CHOQUE_OUT), 0);
        tick();
        chk("setup_pulse", int'(bus.CLV_CHOQUE_OUT), 1);
        tick();
        chk("setup_pulse_end", int'(bus.CLV_CHOQUE_OUT), 0);
        chk("setup_vidas", int'(bus.CLV_VIDAS_OUT), 2);
        for (int k = 0; k < 3; k++) begin
            bus.CLV_CN_IN = 1'b1;
            tick();
            bus.CLV_CN_IN = 1'b0;
            tick();
            tick();
            chk($sformatf("grace_cn%0d", k + 1), int'(bus.CLV_CHOQUE_OUT), 0);
        end
        bus.CLV_CN_IN = 1'b1;
        tick();
        bus.CLV_CN_IN = 1'b0;
        chk("grace_expire_cycle", int'(bus.CLV_CHOQUE_OUT), 0);
        tick();
        chk("rearm_pulse", int'(bus.CLV_CHOQUE_OUT), 1);
        tick();
        chk("rearm_vidas", int'(bus.CLV_VIDAS_OUT), 1);
        chk("rearm_gameover", int'(bus.CLV_GAMEOVER_OUT), 0);

        // Last life: next hit after grace ends the game.
        for (int k = 0; k < 4; k++) begin
            bus.CLV_CN_IN = 1'b1;
            tick();
            bus.CLV_CN_IN = 1'b0;
            tick();
        end
        chk("over_pulse", int'(bus.CLV_CHOQUE_OUT), 1);
        tick();
        chk("over_vidas", int'(bus.CLV_VIDAS_OUT), 0);
        chk("over_gameover", int'(bus.CLV_GAMEOVER_OUT), 1);
        bus.CLV_CN_IN = 1'b1;
        tick();
        bus.CLV_CN_IN = 1'b0;
        tick();
        tick();
        chk("over_hold_gameover", int'(bus.CLV_GAMEOVER_OUT), 1);
        chk("over_hold_choque", int'(bus.CLV_CHOQUE_OUT), 0);
        chk("over_hold_vidas", int'(bus.CLV_VIDAS_OUT), 0);
        bus.CLV_ESTADO_IN = CLV_ESTADO_INICIO;
        tick();
        chk("inicio_gameover", int'(bus.CLV_GAMEOVER_OUT), 0);
        chk("inicio_vidas", int'(bus.CLV_VIDAS_OUT), 3);

        // Paused game with the frog on a vehicle.
        do_reset();
        bus.CLV_ESTADO_IN = 3'b010;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("pause_choque%0d", k), int'(bus.CLV_CHOQUE_OUT), 0);
        end
        chk("pause_vidas", int'(bus.CLV_VIDAS_OUT), 3);

        // Leaving play during grace drops the window; resuming re-detects at once.
        bus.CLV_ESTADO_IN = CLV_ESTADO_JUEGO;
        tick();
        tick();
        chk("resume_pulse", int'(bus.CLV_CHOQUE_OUT), 1);
        tick();
        bus.CLV_ESTADO_IN = 3'b010;
        tick();
        bus.CLV_ESTADO_IN = CLV_ESTADO_JUEGO;
        tick();
        chk("regrace_arm", int'(bus.CLV_CHOQUE_OUT), 0);
        tick();
        chk("regrace_pulse", int'(bus.CLV_CHOQUE_OUT), 1);
        tick();
        chk("regrace_vidas", int'(bus.CLV_VIDAS_OUT), 1);

        // Reset while in grace.
        rst = 1'b1;
        tick();
        chk("rst_grace_choque", int'(bus.CLV_CHOQUE_OUT), 0);
        chk("rst_grace_vidas", int'(bus.CLV_VIDAS_OUT), 3);
        chk("rst_grace_gameover", int'(bus.CLV_GAMEOVER_OUT), 0);
        rst = 1'b0;
        tick();
        tick();
        chk("rst_grace_redetect", int'(bus.CLV_CHOQUE_OUT), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
